// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined MIPS cpu: the machine word type,
// the halt and NOP encodings, and the fetch-stage halt FSM state type.
package cpu_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t HALT_WORD = 32'hffff_ffff;
    localparam word_t NOP_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_halt_fsm.sv
// Halt/drain sequencer for the fetch stage.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   halt_seen     : halt word sits in IF/ID and is not being flushed
//   freeze_c      : combinational; PC and IF/ID must hold this cycle
//   done          : registered; drain complete, held until reset
// DRAIN_CYCLES must be at least 1.
module fetch_halt_fsm
    import cpu_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic halt_seen,
    output logic freeze_c,
    output logic done
);

    localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    // State, drain counter and done flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    // Next state; the halt-detect edge already freezes so the halt word stays in IF/ID
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        freeze_c = 1'b1;
        case (state_q)
            RUN: begin
                freeze_c = halt_seen;
                if (halt_seen) begin
                    cnt_d   = '0;
                    state_d = (CNT_LAST == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = RUN;
            end
        endcase
        done_d = (state_d == DONE);
    end

    assign done = done_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and halt/drain logic.
// Ports:
//   CLOCK, RESET_N          : clock (rising edge), asynchronous active-low reset
//   imem_addr / imem_rdata  : instruction memory byte address (= PC) and word
//   stallF, flushD          : hazard-unit hold of PC+IF/ID, NOP insert into IF/ID
//   jumpD/pc_jumpD          : jump redirect and target
//   pc_srcD/pc_branchD      : taken-branch redirect and target
//   instructionD, pcplus4D  : IF/ID register contents
//   haltD                   : IF/ID holds the halt word
//   done                    : drain complete, held until reset
//   cycle_cnt, instr_cnt    : performance counters, built only when
//                             FETCH_PERF_CNT_EN is defined (else tied to 0)
module fetch_stage
    import cpu_pkg::WORD_W;
    import cpu_pkg::word_t;
    import cpu_pkg::NOP_WORD;
#(
    parameter word_t       RESET_PC     = 32'h0,
    parameter int unsigned IMEM_DEPTH   = 512,
    parameter word_t       HALT_WORD    = cpu_pkg::HALT_WORD,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic              CLOCK,
    input  logic              RESET_N,
    output logic [WORD_W-1:0] imem_addr,
    input  logic [WORD_W-1:0] imem_rdata,
    input  logic              stallF,
    input  logic              flushD,
    input  logic              pc_srcD,
    input  logic [WORD_W-1:0] pc_branchD,
    input  logic              jumpD,
    input  logic [WORD_W-1:0] pc_jumpD,
    output logic [WORD_W-1:0] instructionD,
    output logic [WORD_W-1:0] pcplus4D,
    output logic              haltD,
    output logic              done,
    output logic [WORD_W-1:0] cycle_cnt,
    output logic [WORD_W-1:0] instr_cnt
);

    localparam logic [WORD_W-3:0] DEPTH_WORDS = (WORD_W-2)'(IMEM_DEPTH);
    localparam word_t             ALIGN_MASK  = 32'hffff_fffc;

    word_t pc_q, pc_d;
    word_t instr_q, instr_d;
    word_t pcp4_q, pcp4_d;
    word_t pc_plus4, fetch_word;
    logic  freeze_c, halt_seen;

    assign pc_plus4   = pc_q + 32'd4;
    // Fetching past the end of memory yields the halt word
    assign fetch_word = (pc_q[WORD_W-1:2] < DEPTH_WORDS) ? imem_rdata : HALT_WORD;
    assign haltD      = (instr_q == HALT_WORD);
    assign halt_seen  = haltD & ~flushD;

    fetch_halt_fsm #(
        .DRAIN_CYCLES(DRAIN_CYCLES)
    ) u_halt_fsm (
        .clk      (CLOCK),
        .rst_n    (RESET_N),
        .halt_seen(halt_seen),
        .freeze_c (freeze_c),
        .done     (done)
    );

    // Next PC and IF/ID contents
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pcp4_d  = pcp4_q;
        if (!freeze_c && !stallF) begin
            if (jumpD) begin
                pc_d = pc_jumpD & ALIGN_MASK;
            end else if (pc_srcD) begin
                pc_d = pc_branchD & ALIGN_MASK;
            end else begin
                pc_d = pc_plus4;
            end
        end
        // Flush overrides stall and freeze
        if (flushD) begin
            instr_d = NOP_WORD;
            pcp4_d  = '0;
        end else if (!freeze_c && !stallF) begin
            instr_d = fetch_word;
            pcp4_d  = pc_plus4;
        end
    end

    // PC and IF/ID registers
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_WORD;
            pcp4_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pcp4_q  <= pcp4_d;
        end
    end

    assign imem_addr    = pc_q;
    assign instructionD = instr_q;
    assign pcplus4D     = pcp4_q;

`ifdef FETCH_PERF_CNT_EN
    word_t cycle_q, instr_cnt_q;
    logic  load_c;

    assign load_c = ~flushD & ~freeze_c & ~stallF;

    // Performance counters, modulo 2^32
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            cycle_q     <= '0;
            instr_cnt_q <= '0;
        end else begin
            if (!done) begin
                cycle_q <= cycle_q + 32'd1;
            end
            if (load_c) begin
                instr_cnt_q <= instr_cnt_q + 32'd1;
            end
        end
    end

    assign cycle_cnt = cycle_q;
    assign instr_cnt = instr_cnt_q;
`else
    assign cycle_cnt = '0;
    assign instr_cnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// control traffic, checked every cycle against a behavioural reference model
// through an expectation queue drained by an independent monitor.
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int unsigned DEPTH    = 512;
    localparam logic [31:0] HALT     = 32'hffff_ffff;
    localparam int unsigned DRAIN    = 2;

    localparam logic [31:0] WA = 32'h2001_0001;
    localparam logic [31:0] WB = 32'h2002_0002;
    localparam logic [31:0] WC = 32'h2003_0003;

    logic        CLOCK = 1'b0;
    logic        RESET_N;
    logic [31:0] imem_addr, imem_rdata, pc_branchD, pc_jumpD;
    logic [31:0] instructionD, pcplus4D, cycle_cnt, instr_cnt;
    logic        stallF, flushD, pc_srcD, jumpD, haltD, done;

    logic [31:0] mem [DEPTH];

    always #5 CLOCK = ~CLOCK;

    // Behavioural memory; out-of-range reads return junk the DUT must replace
    assign imem_rdata = (imem_addr[31:2] < 30'(DEPTH)) ? mem[imem_addr[10:2]]
                                                       : (imem_addr ^ 32'h5a5a_a5a5);

    fetch_stage #(
        .RESET_PC    (RESET_PC),
        .IMEM_DEPTH  (DEPTH),
        .HALT_WORD   (HALT),
        .DRAIN_CYCLES(DRAIN)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET_N     (RESET_N),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .stallF      (stallF),
        .flushD      (flushD),
        .pc_srcD     (pc_srcD),
        .pc_branchD  (pc_branchD),
        .jumpD       (jumpD),
        .pc_jumpD    (pc_jumpD),
        .instructionD(instructionD),
        .pcplus4D    (pcplus4D),
        .haltD       (haltD),
        .done        (done),
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ir;
        logic [31:0] p4;
        logic [31:0] cyc;
        logic [31:0] icnt;
        logic        halt;
        logic        done;
    } exp_t;

    exp_t q[$];

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 = running, 1 = draining, 2 = finished
    logic [31:0] m_pc, m_ir, m_p4, m_cyc, m_icnt;
    int          m_mode, m_left;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fill_mem(input int halt_idx);
        logic [31:0] w;
        for (int i = 0; i < int'(DEPTH); i++) begin
            do w = $urandom; while (w == HALT);
            mem[i] = w;
        end
        if (halt_idx >= 0) mem[halt_idx] = HALT;
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_ir = 32'h0; m_p4 = 32'h0;
        m_cyc = 32'h0; m_icnt = 32'h0;
        m_mode = 0; m_left = 0;
    endtask

    // Asserts reset asynchronously, checks reset state at once, releases at a negedge
    task automatic do_reset();
        RESET_N = 1'b0;
        stallF = 1'b0; flushD = 1'b0; jumpD = 1'b0; pc_srcD = 1'b0;
        pc_jumpD = 32'h0; pc_branchD = 32'h0;
        #1;
        chk("rst_imem_addr", imem_addr, RESET_PC);
        chk("rst_instructionD", instructionD, 32'h0);
        chk("rst_pcplus4D", pcplus4D, 32'h0);
        chk("rst_haltD", 32'(haltD), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_cycle_cnt", cycle_cnt, 32'h0);
        chk("rst_instr_cnt", instr_cnt, 32'h0);
        q.delete();
        model_reset();
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
    endtask

    // Drives one cycle of inputs, advances the model, queues the post-edge expectation
    task automatic step(input bit s, input bit f, input bit j, input logic [31:0] jt,
                        input bit b, input logic [31:0] bt);
        logic [31:0] fetched;
        bit          halt_now, hold;
        exp_t        e;
        stallF = s; flushD = f; jumpD = j; pc_jumpD = jt; pc_srcD = b; pc_branchD = bt;
        fetched  = (m_pc[31:2] < 30'(DEPTH)) ? mem[m_pc[10:2]] : HALT;
        halt_now = (m_mode == 0) && (m_ir == HALT) && !f;
        hold     = (m_mode != 0) || halt_now || s;
        if (m_mode != 2) m_cyc = m_cyc + 32'd1;
        if (f) begin
            m_ir = 32'h0; m_p4 = 32'h0;
        end else if (!hold) begin
            m_ir = fetched; m_p4 = m_pc + 32'd4; m_icnt = m_icnt + 32'd1;
        end
        if (!hold) begin
            if (j)      m_pc = jt & 32'hffff_fffc;
            else if (b) m_pc = bt & 32'hffff_fffc;
            else        m_pc = m_pc + 32'd4;
        end
        if (halt_now) begin
            m_left = int'(DRAIN) - 1;
            m_mode = (m_left == 0) ? 2 : 1;
        end else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
        e.addr = m_pc;
        e.ir   = m_ir;
        e.p4   = m_p4;
        e.halt = (m_ir == HALT);
        e.done = (m_mode == 2);
        e.cyc  = PERF ? m_cyc  : 32'h0;
        e.icnt = PERF ? m_icnt : 32'h0;
        q.push_back(e);
        @(negedge CLOCK);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    // Monitor: compares DUT outputs shortly after every active edge
    initial begin
        exp_t e;
        forever begin
            @(posedge CLOCK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("imem_addr", imem_addr, e.addr);
                chk("instructionD", instructionD, e.ir);
                chk("pcplus4D", pcplus4D, e.p4);
                chk("haltD", 32'(haltD), 32'(e.halt));
                chk("done", 32'(done), 32'(e.done));
                chk("cycle_cnt", cycle_cnt, e.cyc);
                chk("instr_cnt", instr_cnt, e.icnt);
            end
        end
    end

    initial begin
        int          tail;
        bit          s, f, j, b;
        logic [31:0] jt, bt;

        RESET_N = 1'b1;
        stallF = 1'b0; flushD = 1'b0; jumpD = 1'b0; pc_srcD = 1'b0;
        pc_jumpD = 32'h0; pc_branchD = 32'h0;
        model_reset();
        #2;

        // Straight-line fetch into halt and drain
        fill_mem(3);
        mem[0] = WA; mem[1] = WB; mem[2] = WC;
        do_reset();
        step(0, 0, 0, 32'h0, 0, 32'h0);
        chk("sl_first", instructionD, WA);
        idle(3);
        chk("sl_halt_word", instructionD, HALT);
        chk("sl_haltD", 32'(haltD), 32'h1);
        idle(1);
        chk("sl_not_done_5", 32'(done), 32'h0);
        idle(1);
        chk("sl_done_6", 32'(done), 32'h1);
        chk("sl_cycle_cnt", cycle_cnt, PERF ? 32'd6 : 32'd0);
        chk("sl_instr_cnt", instr_cnt, PERF ? 32'd4 : 32'd0);
        idle(3);
        chk("sl_frozen_addr", imem_addr, 32'h10);

        // Stall, stall against jump, branch with flush
        fill_mem(-1);
        mem[0] = WA; mem[1] = WB; mem[2] = WC;
        do_reset();
        idle(2);
        chk("st_ir_b", instructionD, WB);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        step(1, 0, 0, 32'h0, 0, 32'h0);
        chk("st_addr_held", imem_addr, 32'h8);
        chk("st_ir_held", instructionD, WB);
        idle(1);
        chk("st_resume_c", instructionD, WC);
        step(1, 0, 1, 32'h80, 0, 32'h0);
        chk("sj_pc_held", imem_addr, 32'hc);
        step(0, 0, 1, 32'h80, 0, 32'h0);
        chk("sj_pc_jump", imem_addr, 32'h80);
        step(0, 1, 0, 32'h0, 1, 32'h40);
        chk("bf_addr", imem_addr, 32'h40);
        chk("bf_nop", instructionD, 32'h0);
        idle(1);
        chk("bf_word16", instructionD, mem[16]);
        step(0, 0, 1, 32'hffff_fffe, 0, 32'h0);
        chk("align_wrap_addr", imem_addr, 32'hffff_fffc);
        idle(1);
        chk("wrap_to_zero", imem_addr, 32'h0);
        idle(4);

        // Wrong-path halt is flushed and does not stop the CPU
        fill_mem(3);
        do_reset();
        idle(4);
        chk("wp_haltD", 32'(haltD), 32'h1);
        step(0, 1, 0, 32'h0, 1, 32'h40);
        idle(6);
        chk("wp_not_done", 32'(done), 32'h0);

        // End of memory
        fill_mem(-1);
        do_reset();
        step(0, 0, 1, 32'h7fc, 0, 32'h0);
        idle(1);
        chk("eom_last_word", instructionD, mem[511]);
        chk("eom_addr", imem_addr, 32'h800);
        idle(1);
        chk("eom_halt", instructionD, HALT);
        idle(3);
        chk("eom_done", 32'(done), 32'h1);

        // Reset while draining
        fill_mem(3);
        do_reset();
        idle(5);
        do_reset();
        idle(3);

        // Randomized control traffic
        for (int ph = 0; ph < 25; ph++) begin
            fill_mem(($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 60)) : -1);
            do_reset();
            tail = 0;
            for (int n = 0; n < 150 && tail < 4; n++) begin
                s  = ($urandom_range(0, 99) < 20);
                f  = ($urandom_range(0, 99) < 15);
                j  = ($urandom_range(0, 99) < 10);
                b  = ($urandom_range(0, 99) < 10);
                jt = ($urandom_range(0, 19) == 0) ? $urandom : $urandom_range(0, 32'h880);
                bt = $urandom_range(0, 32'h880);
                if ($urandom_range(0, 199) == 0) do_reset();
                else step(s, f, j, jt, b, bt);
                if (m_mode == 2) tail++;
            end
        end

        repeat (3) @(negedge CLOCK);
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
